// File: rtl/vram_arbiter.sv
// Screen RAM (bank 2) arbiter between the Z80 and the video fetch unit.
// Video has fixed priority; a starvation counter guarantees the CPU a slot.
module vram_arbiter #(
  parameter int AW           = 13,
  parameter int DW           = 8,
  parameter int MAX_CPU_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_cs,
  input  logic          cpu_rd_n,
  input  logic          cpu_wr_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_wait_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [DW-1:0] vid_rdata,
  output logic          bank_en,
  output logic          bank_we,
  output logic [AW-1:0] bank_addr,
  output logic [DW-1:0] bank_wdata,
  input  logic [DW-1:0] bank_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    VID_ISSUE,
    VID_CAP,
    CPU_ISSUE,
    CPU_CAP,
    CPU_HOLD
  } state_t;

  localparam logic [7:0] MAX_WAIT = 8'(MAX_CPU_WAIT);

  state_t        state_q, state_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic          bank_en_q, bank_en_d;
  logic          bank_we_q, bank_we_d;
  logic [AW-1:0] bank_addr_q, bank_addr_d;
  logic [DW-1:0] bank_wdata_q, bank_wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] vid_rdata_q, vid_rdata_d;
  logic          vid_ack_q, vid_ack_d;

  logic cpu_req;
  logic cpu_grant;
  logic waiting_state;

  assign cpu_req       = cpu_cs & (~cpu_rd_n | ~cpu_wr_n);
  assign cpu_grant     = (state_q == IDLE) & cpu_req & (~vid_req | (wait_cnt_q == MAX_WAIT));
  assign waiting_state = (state_q == IDLE) | (state_q == VID_ISSUE) | (state_q == VID_CAP);

  // WAIT must never stall the Z80 while the system is held in reset.
  assign cpu_wait_n = ~(cpu_req & (state_q != CPU_HOLD)) | ~rst_n;

  assign cpu_rdata  = cpu_rdata_q;
  assign vid_ack    = vid_ack_q;
  assign vid_rdata  = vid_rdata_q;
  assign bank_en    = bank_en_q;
  assign bank_we    = bank_we_q;
  assign bank_addr  = bank_addr_q;
  assign bank_wdata = bank_wdata_q;

  always_comb begin
    state_d      = state_q;
    bank_en_d    = 1'b0;
    bank_we_d    = 1'b0;
    bank_addr_d  = bank_addr_q;
    bank_wdata_d = bank_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    vid_rdata_d  = vid_rdata_q;
    vid_ack_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_grant) begin
          state_d      = CPU_ISSUE;
          bank_en_d    = 1'b1;
          bank_we_d    = ~cpu_wr_n;
          bank_addr_d  = cpu_addr;
          bank_wdata_d = cpu_wdata;
        end else if (vid_req) begin
          state_d     = VID_ISSUE;
          bank_en_d   = 1'b1;
          bank_addr_d = vid_addr;
        end
      end
      VID_ISSUE: state_d = VID_CAP;
      VID_CAP: begin
        state_d     = IDLE;
        vid_rdata_d = bank_rdata;
        vid_ack_d   = 1'b1;
      end
      // bank_we_q still reflects the granted access during the issue cycle.
      CPU_ISSUE: state_d = bank_we_q ? CPU_HOLD : CPU_CAP;
      CPU_CAP: begin
        state_d     = CPU_HOLD;
        cpu_rdata_d = bank_rdata;
      end
      CPU_HOLD: begin
        if (!cpu_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!cpu_req || cpu_grant) begin
      wait_cnt_d = 8'd0;
    end else if (waiting_state && (wait_cnt_q < MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wait_cnt_q   <= 8'd0;
      bank_en_q    <= 1'b0;
      bank_we_q    <= 1'b0;
      bank_addr_q  <= '0;
      bank_wdata_q <= '0;
      cpu_rdata_q  <= '0;
      vid_rdata_q  <= '0;
      vid_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      bank_en_q    <= bank_en_d;
      bank_we_q    <= bank_we_d;
      bank_addr_q  <= bank_addr_d;
      bank_wdata_q <= bank_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      vid_rdata_q  <= vid_rdata_d;
      vid_ack_q    <= vid_ack_d;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a one-cycle-latency RAM model.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_cs, cpu_rd_n, cpu_wr_n;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_wait_n;
  logic        vid_req;
  logic [12:0] vid_addr;
  logic        vid_ack;
  logic [7:0]  vid_rdata;
  logic        bank_en, bank_we;
  logic [12:0] bank_addr;
  logic [7:0]  bank_wdata;
  logic [7:0]  bank_rdata;

  logic [7:0]  mem [0:8191];
  logic        init_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.AW(13), .DW(8), .MAX_CPU_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_cs(cpu_cs), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_wait_n(cpu_wait_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
  );

  // Synchronous RAM: data appears the cycle after en is sampled.
  always @(posedge clk) begin
    if (!init_done) begin
      mem[13'h0000] <= 8'h11;
      mem[13'h0001] <= 8'h22;
      mem[13'h0123] <= 8'hA5;
    end else if (bank_en) begin
      if (bank_we) mem[bank_addr] <= bank_wdata;
      bank_rdata <= mem[bank_addr];
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; cpu_cs = 1'b1; cpu_rd_n = 1'b0; cpu_wr_n = 1'b1;
    cpu_addr = 13'h0123; cpu_wdata = 8'h00; vid_req = 1'b0; vid_addr = 13'h0000;
    init_done = 1'b0;

    // Reset with a CPU read already requested
    tick(); tick();
    init_done = 1'b1;
    chk("rst_wait_n", 32'(cpu_wait_n), 32'h1);
    chk("rst_bank_en", 32'(bank_en), 32'h0);
    chk("rst_vid_ack", 32'(vid_ack), 32'h0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
    chk("rst_vid_rdata", 32'(vid_rdata), 32'h0);
    chk("rst_bank_addr", 32'(bank_addr), 32'h0);
    $display("step reset: wait_n=%0b bank_en=%0b", cpu_wait_n, bank_en);

    rst_n = 1'b1; #1;
    chk("rel_wait_n0", 32'(cpu_wait_n), 32'h0);
    tick();
    chk("rd_grant_en", 32'(bank_en), 32'h1);
    chk("rd_grant_we", 32'(bank_we), 32'h0);
    chk("rd_grant_addr", 32'(bank_addr), 32'h0123);
    chk("rd_issue_wait", 32'(cpu_wait_n), 32'h0);
    tick();
    chk("rd_cap_en", 32'(bank_en), 32'h0);
    chk("rd_cap_wait", 32'(cpu_wait_n), 32'h0);
    tick();
    chk("rd_hold_wait", 32'(cpu_wait_n), 32'h1);
    chk("rd_hold_data", 32'(cpu_rdata), 32'hA5);
    tick();
    chk("rd_hold2_data", 32'(cpu_rdata), 32'hA5);
    chk("rd_hold2_en", 32'(bank_en), 32'h0);
    $display("step cpu read 0123: rdata=%0h", cpu_rdata);
    cpu_rd_n = 1'b1;
    tick();
    chk("rd_exit_en", 32'(bank_en), 32'h0);

    // CPU write 0x5A to 0x1FFF
    cpu_wr_n = 1'b0; cpu_addr = 13'h1FFF; cpu_wdata = 8'h5A; #1;
    chk("wr_req_wait", 32'(cpu_wait_n), 32'h0);
    tick();
    chk("wr_en", 32'(bank_en), 32'h1);
    chk("wr_we", 32'(bank_we), 32'h1);
    chk("wr_addr", 32'(bank_addr), 32'h1FFF);
    chk("wr_wdata", 32'(bank_wdata), 32'h5A);
    cpu_wdata = 8'hFF;
    tick();
    chk("wr_hold_wait", 32'(cpu_wait_n), 32'h1);
    chk("wr_hold_we", 32'(bank_we), 32'h0);
    chk("wr_hold_en", 32'(bank_en), 32'h0);
    chk("wr_mem", 32'(mem[13'h1FFF]), 32'h5A);
    $display("step cpu write 1fff: mem=%0h", mem[13'h1FFF]);
    cpu_wr_n = 1'b1;
    tick();
    cpu_rd_n = 1'b0;
    tick(); tick(); tick();
    chk("rdback_wait", 32'(cpu_wait_n), 32'h1);
    chk("rdback_data", 32'(cpu_rdata), 32'h5A);
    $display("step cpu readback 1fff: rdata=%0h", cpu_rdata);
    cpu_rd_n = 1'b1; cpu_cs = 1'b0;
    tick();

    // Video only, back-to-back fetches
    vid_req = 1'b1; vid_addr = 13'h0000;
    tick();
    chk("vid0_en", 32'(bank_en), 32'h1);
    chk("vid0_addr", 32'(bank_addr), 32'h0000);
    chk("vid0_ack_lo", 32'(vid_ack), 32'h0);
    vid_addr = 13'h0001;
    tick();
    chk("vid0_cap_en", 32'(bank_en), 32'h0);
    chk("vid0_cap_ack", 32'(vid_ack), 32'h0);
    tick();
    chk("vid0_ack", 32'(vid_ack), 32'h1);
    chk("vid0_data", 32'(vid_rdata), 32'h11);
    $display("step video 0000: ack=%0b data=%0h", vid_ack, vid_rdata);
    tick();
    chk("vid1_ack_lo", 32'(vid_ack), 32'h0);
    chk("vid1_en", 32'(bank_en), 32'h1);
    chk("vid1_addr", 32'(bank_addr), 32'h0001);
    tick(); tick();
    chk("vid1_ack", 32'(vid_ack), 32'h1);
    chk("vid1_data", 32'(vid_rdata), 32'h22);
    $display("step video 0001: ack=%0b data=%0h", vid_ack, vid_rdata);
    vid_req = 1'b0;
    tick();
    chk("vid_idle_en", 32'(bank_en), 32'h0);

    // Video request dropped right after grant still completes
    vid_req = 1'b1; vid_addr = 13'h0123;
    tick();
    chk("vabort_en", 32'(bank_en), 32'h1);
    vid_req = 1'b0;
    tick(); tick();
    chk("vabort_ack", 32'(vid_ack), 32'h1);
    chk("vabort_data", 32'(vid_rdata), 32'hA5);
    $display("step video abort: ack=%0b data=%0h", vid_ack, vid_rdata);
    tick();
    chk("vabort_ack_lo", 32'(vid_ack), 32'h0);
    chk("vabort_idle", 32'(bank_en), 32'h0);

    // Contention: simultaneous requests, video first, CPU once the counter saturates
    vid_req = 1'b1; vid_addr = 13'h0000;
    cpu_cs = 1'b1; cpu_rd_n = 1'b0; cpu_addr = 13'h1FFF;
    tick();
    chk("ct_e1_addr", 32'(bank_addr), 32'h0000);
    chk("ct_e1_wait", 32'(cpu_wait_n), 32'h0);
    tick(); tick();
    chk("ct_e3_ack", 32'(vid_ack), 32'h1);
    tick();
    chk("ct_e4_en", 32'(bank_en), 32'h1);
    chk("ct_e4_addr", 32'(bank_addr), 32'h0000);
    tick(); tick();
    chk("ct_e6_ack", 32'(vid_ack), 32'h1);
    chk("ct_e6_wait", 32'(cpu_wait_n), 32'h0);
    tick();
    chk("ct_e7_en", 32'(bank_en), 32'h1);
    chk("ct_e7_addr", 32'(bank_addr), 32'h1FFF);
    chk("ct_e7_we", 32'(bank_we), 32'h0);
    tick(); tick();
    chk("ct_e9_wait", 32'(cpu_wait_n), 32'h1);
    chk("ct_e9_data", 32'(cpu_rdata), 32'h5A);
    $display("step contention: cpu rdata=%0h", cpu_rdata);
    cpu_rd_n = 1'b1;
    tick();
    chk("ct_e10_en", 32'(bank_en), 32'h0);
    tick();
    chk("ct_e11_en", 32'(bank_en), 32'h1);
    chk("ct_e11_addr", 32'(bank_addr), 32'h0000);
    vid_req = 1'b0;
    tick(); tick();
    chk("ct_e13_ack", 32'(vid_ack), 32'h1);
    tick();

    // Reset asserted while a CPU read is in CPU_CAP
    cpu_rd_n = 1'b0; cpu_addr = 13'h0123;
    tick(); tick();
    chk("rcap_pre_en", 32'(bank_en), 32'h0);
    rst_n = 1'b0; #1;
    chk("rcap_rdata", 32'(cpu_rdata), 32'h0);
    chk("rcap_wait", 32'(cpu_wait_n), 32'h1);
    tick();
    chk("rcap_en", 32'(bank_en), 32'h0);
    chk("rcap_ack", 32'(vid_ack), 32'h0);
    cpu_rd_n = 1'b1; cpu_cs = 1'b0; rst_n = 1'b1;
    tick();
    chk("rcap_post_en", 32'(bank_en), 32'h0);
    chk("rcap_post_wait", 32'(cpu_wait_n), 32'h1);
    cpu_cs = 1'b1; cpu_rd_n = 1'b0; cpu_addr = 13'h0001;
    tick();
    chk("rcap_idle_grant", 32'(bank_en), 32'h1);
    chk("rcap_idle_addr", 32'(bank_addr), 32'h0001);
    tick(); tick();
    chk("rcap_after_data", 32'(cpu_rdata), 32'h22);
    $display("step reset in cap: rdata after=%0h", cpu_rdata);
    cpu_rd_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
